// File: rtl/bus_slave_mem.sv
// Memory-backed bus slave: ID decode, single-beat read/write with WAIT_STATES latency.
// Define SLAVE_MEM_ERR_RESP_EN to flag out-of-range offsets with s_err; otherwise offsets wrap.
module bus_slave_mem #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ID_BITS     = 4,
    parameter int unsigned SLAVE_ID    = 2,
    parameter int unsigned MEM_DEPTH   = 4096,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  s_valid,
    input  logic [ADDR_WIDTH-1:0] s_addr,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wen,
    output logic                  s_ready,
    output logic                  s_rvalid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic                  s_err
);
    localparam int unsigned OffW  = ADDR_WIDTH - ID_BITS;
    localparam int unsigned OffW1 = OffW + 1;
    localparam int unsigned MemAw = $clog2(MEM_DEPTH);
    localparam logic [ID_BITS-1:0] MyId     = ID_BITS'(SLAVE_ID);
    localparam logic [3:0]         WaitCnt  = 4'(WAIT_STATES);
    localparam bit                 ZeroWait = (WAIT_STATES == 0);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [OffW-1:0]       off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  req_hit;
    logic                  commit;
    logic [OffW-1:0]       c_off;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_wen;
    logic [MemAw-1:0]      c_idx;
    logic                  c_ok;
    logic                  unused_off;

    assign req_hit    = s_valid && (s_addr[ADDR_WIDTH-1 -: ID_BITS] == MyId);
    assign c_idx      = c_off[MemAw-1:0];
    assign unused_off = ^c_off;

`ifdef SLAVE_MEM_ERR_RESP_EN
    localparam logic [OffW:0] DepthLim = OffW1'(MEM_DEPTH);
    assign c_ok = ({1'b0, c_off} < DepthLim);
`else
    assign c_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        c_off   = off_q;
        c_wdata = wdata_q;
        c_wen   = wen_q;
        case (state_q)
            StIdle: begin
                if (req_hit) begin
                    off_d   = s_addr[OffW-1:0];
                    wdata_d = s_wdata;
                    wen_d   = s_wen;
                    cnt_d   = WaitCnt;
                    if (ZeroWait) begin
                        // With no wait states the accept edge is also the commit edge.
                        commit  = 1'b1;
                        c_off   = s_addr[OffW-1:0];
                        c_wdata = s_wdata;
                        c_wen   = s_wen;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (commit) begin
            rdata_d = (c_wen || !c_ok) ? '0 : mem[c_idx];
            err_d   = !c_ok;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM has no reset; a request seen while rstn is low must not write.
    always_ff @(posedge clk) begin
        if (rstn && commit && c_wen && c_ok) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign s_ready  = (state_q == StIdle);
    assign s_rvalid = (state_q == StResp);
    assign s_rdata  = rdata_q;
`ifdef SLAVE_MEM_ERR_RESP_EN
    assign s_err    = err_q;
`else
    assign s_err    = 1'b0;
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Bench for bus_slave_mem: two instances (defaults; 2048 words with no wait states) share
// one request stream and are checked every cycle against a timestamp/array reference model.
module tb_bus_slave_mem;
`ifdef SLAVE_MEM_ERR_RESP_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rstn    = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_addr  = '0;
    logic [7:0]  s_wdata = '0;
    logic        s_wen   = 1'b0;
    logic [1:0]  rdy, rv, er;
    logic [7:0]  rd0, rd1;

    bus_slave_mem u_dut0 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wen(s_wen), .s_ready(rdy[0]), .s_rvalid(rv[0]), .s_rdata(rd0), .s_err(er[0])
    );

    bus_slave_mem #(.MEM_DEPTH(2048), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wen(s_wen), .s_ready(rdy[1]), .s_rvalid(rv[1]), .s_rdata(rd1), .s_err(er[1])
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    function automatic int wt(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int dep(input int i);
        return (i == 0) ? 4096 : 2048;
    endfunction

    // Reference model: a transaction accepted at edge k commits and responds at edge k+W,
    // and the slave is busy through edge k+W.
    int          e = 0;
    int          busy_thr[2]  = '{-10, -10};
    int          commit_at[2] = '{-10, -10};
    logic [11:0] p_off[2];
    logic [7:0]  p_wd[2];
    bit          p_wen[2];
    bit          exp_rdy[2]   = '{1'b1, 1'b1};
    bit          exp_rv[2]    = '{1'b0, 1'b0};
    bit          exp_err[2];
    bit          exp_known[2];
    logic [7:0]  exp_rd[2];
    bit [7:0]    mm[int];

    initial forever begin
        @(posedge clk);
        e++;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                busy_thr[i]  = -10;
                commit_at[i] = -10;
                exp_rdy[i]   = 1'b1;
                exp_rv[i]    = 1'b0;
            end else begin
                if ((e - 1 > busy_thr[i]) && s_valid && (s_addr[15:12] == 4'd2)) begin
                    p_off[i]     = s_addr[11:0];
                    p_wd[i]      = s_wdata;
                    p_wen[i]     = s_wen;
                    commit_at[i] = e + wt(i);
                    busy_thr[i]  = e + wt(i);
                end
                if (e == commit_at[i]) begin
                    bit oor;
                    int key;
                    oor = ErrEn && (int'(p_off[i]) >= dep(i));
                    key = i * 65536 + (int'(p_off[i]) % dep(i));
                    exp_err[i] = oor;
                    if (p_wen[i]) begin
                        if (!oor) mm[key] = p_wd[i];
                        exp_rd[i]    = 8'h00;
                        exp_known[i] = 1'b1;
                    end else if (oor) begin
                        exp_rd[i]    = 8'h00;
                        exp_known[i] = 1'b1;
                    end else if (mm.exists(key)) begin
                        exp_rd[i]    = mm[key];
                        exp_known[i] = 1'b1;
                    end else begin
                        exp_known[i] = 1'b0;
                    end
                end
                exp_rdy[i] = (e > busy_thr[i]);
                exp_rv[i]  = (e == commit_at[i]);
            end
        end
    end

    int         rv_cnt[2]  = '{0, 0};
    logic [7:0] last_rd[2] = '{8'h00, 8'h00};
    bit         last_err[2];

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] rdv;
            rdv = (i == 0) ? rd0 : rd1;
            if (!rstn) begin
                chk("rst_ready", i, 32'(rdy[i]), 32'd1);
                chk("rst_rvalid", i, 32'(rv[i]), 32'd0);
                chk("rst_rdata", i, 32'(rdv), 32'd0);
                chk("rst_err", i, 32'(er[i]), 32'd0);
            end else begin
                chk("ready", i, 32'(rdy[i]), 32'(exp_rdy[i]));
                chk("rvalid", i, 32'(rv[i]), 32'(exp_rv[i]));
                if (rv[i] === 1'b1) begin
                    rv_cnt[i]++;
                    last_rd[i]  = rdv;
                    last_err[i] = er[i];
                    if (exp_rv[i]) begin
                        chk("err", i, 32'(er[i]), 32'(exp_err[i]));
                        if (exp_known[i]) chk("rdata", i, 32'(rdv), 32'(exp_rd[i]));
                    end
                end
            end
        end
    end

    int lat[2];

    task automatic wait_idle();
        int tries = 0;
        do begin
            @(posedge clk);
            #2;
            tries++;
        end while (rdy != 2'b11 && tries < 50);
        chk("idle_before_req", 0, 32'(rdy), 32'h3);
    endtask

    task automatic xact(input logic [15:0] a, input logic [7:0] d, input bit w);
        wait_idle();
        s_valid = 1'b1;
        s_addr  = a;
        s_wdata = d;
        s_wen   = w;
        @(posedge clk);
        #2;
        s_valid = 1'b0;
        lat = '{-1, -1};
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (rv[0] === 1'b1 && lat[0] < 0) lat[0] = j;
            if (rv[1] === 1'b1 && lat[1] < 0) lat[1] = j;
        end
    endtask

    initial begin
        int c0, c1;
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        chk("reset_ready", 0, 32'(rdy[0]), 32'd1);
        chk("reset_rdata", 0, 32'(rd0), 32'd0);

        // Write, latency, out-of-range handling on the 2048-word instance
        xact(16'h22BC, 8'h5A, 1'b1);
        xact(16'h2ABC, 8'h29, 1'b1);
        chk("lat_w2", 0, 32'(lat[0]), 32'd2);
        chk("lat_w0", 1, 32'(lat[1]), 32'd0);
        chk("wr_err", 0, 32'(last_err[0]), 32'd0);
        chk("wr_err", 1, 32'(last_err[1]), 32'(ErrEn));
        chk("wr_rdata", 1, 32'(last_rd[1]), 32'd0);
        xact(16'h2ABC, 8'h00, 1'b0);
        chk("rd_2abc", 0, 32'(last_rd[0]), 32'h29);
        chk("rd_2abc", 1, 32'(last_rd[1]), ErrEn ? 32'h00 : 32'h29);
        chk("rd_2abc_err", 1, 32'(last_err[1]), 32'(ErrEn));
        xact(16'h22BC, 8'h00, 1'b0);
        chk("rd_22bc", 0, 32'(last_rd[0]), 32'h5A);
        chk("rd_22bc", 1, 32'(last_rd[1]), ErrEn ? 32'h5A : 32'h29);

        // ID mismatch is ignored
        xact(16'h29AC, 8'h11, 1'b1);
        wait_idle();
        c0 = rv_cnt[0];
        c1 = rv_cnt[1];
        s_valid = 1'b1; s_addr = 16'h09AC; s_wdata = 8'h54; s_wen = 1'b1;
        @(posedge clk);
        #2 s_valid = 1'b0;
        @(negedge clk);
        chk("idmiss_ready", 0, 32'(rdy), 32'h3);
        repeat (4) @(negedge clk);
        chk("idmiss_rv", 0, 32'(rv_cnt[0]), 32'(c0));
        chk("idmiss_rv", 1, 32'(rv_cnt[1]), 32'(c1));
        xact(16'h29AC, 8'h00, 1'b0);
        chk("rd_29ac", 0, 32'(last_rd[0]), 32'h11);
        chk("rd_29ac", 1, 32'(last_rd[1]), ErrEn ? 32'h00 : 32'h11);

        // Request while busy is dropped; retry succeeds
        xact(16'h2001, 8'h33, 1'b1);
        wait_idle();
        c0 = rv_cnt[0];
        c1 = rv_cnt[1];
        s_valid = 1'b1; s_addr = 16'h2100; s_wdata = 8'h77; s_wen = 1'b1;
        @(posedge clk);
        #2 s_addr = 16'h2001; s_wdata = 8'hAA;
        @(posedge clk);
        #2 s_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_one_rv", 0, 32'(rv_cnt[0] - c0), 32'd1);
        chk("busy_one_rv", 1, 32'(rv_cnt[1] - c1), 32'd1);
        xact(16'h2001, 8'h00, 1'b0);
        chk("busy_unwritten", 0, 32'(last_rd[0]), 32'h33);
        chk("busy_unwritten", 1, 32'(last_rd[1]), 32'h33);
        xact(16'h2001, 8'hAA, 1'b1);
        xact(16'h2001, 8'h00, 1'b0);
        chk("retry_stored", 0, 32'(last_rd[0]), 32'hAA);
        chk("retry_stored", 1, 32'(last_rd[1]), 32'hAA);

        // Reset one cycle after accept: pending write on the waiting instance is lost
        xact(16'h2050, 8'h44, 1'b1);
        wait_idle();
        c0 = rv_cnt[0];
        c1 = rv_cnt[1];
        s_valid = 1'b1; s_addr = 16'h2050; s_wdata = 8'hEE; s_wen = 1'b1;
        @(posedge clk);
        #2 s_valid = 1'b0;
        @(posedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        chk("midrst_ready", 0, 32'(rdy), 32'h3);
        chk("midrst_rvalid", 0, 32'(rv), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_rv", 0, 32'(rv_cnt[0]), 32'(c0));
        chk("midrst_rv", 1, 32'(rv_cnt[1]), 32'(c1 + 1));
        xact(16'h2050, 8'h00, 1'b0);
        chk("midrst_lost", 0, 32'(last_rd[0]), 32'h44);
        chk("midrst_kept", 1, 32'(last_rd[1]), 32'hEE);

        // Randomized traffic, mostly to this slave, offsets straddling the 2048 boundary
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk);
            #2;
            if (n == 700) rstn = 1'b0;
            if (n == 702) rstn = 1'b1;
            s_valid = 1'($urandom_range(0, 1));
            s_addr[15:12] = ($urandom_range(0, 3) != 0) ? 4'd2 : 4'($urandom_range(0, 15));
            s_addr[11:0]  = ($urandom_range(0, 1) != 0 ? 12'h800 : 12'h000)
                            | 12'($urandom_range(0, 15));
            s_wdata = 8'($urandom_range(0, 255));
            s_wen   = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #2 s_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_slave_mem.md
# bus_slave_mem

Memory-backed responder for the system bus: the slave end of the master request handshake (addr / wdata / wen / valid → ready). It decodes the device ID in the upper address bits and executes single-beat reads and writes against a local RAM with a programmable number of wait states. It returns a one-cycle response strobe with read data. One instance sits behind each slave port of the bus interconnect.

## Interface
- ADDR_WIDTH, 16 — bus address width
- DATA_WIDTH, 8 — data width
- ID_BITS, 4 — upper address bits used as device ID
- SLAVE_ID, 2 — ID this instance responds to
- MEM_DEPTH, 4096 — RAM words; ≤ 2^(ADDR_WIDTH-ID_BITS)
- WAIT_STATES, 2 — access latency cycles, 0..15

Ports:
- clk  in  1  — single clock; all logic on rising edge
- rstn  in  1  — reset, asynchronous, active-low
- s_valid  in  1  — request strobe from bus
- s_addr  in  ADDR_WIDTH  — [ADDR_WIDTH-1 -: ID_BITS] = ID, remaining bits = offset
- s_wdata  in  DATA_WIDTH  — write data
- s_wen  in  1  — 1 = write, 0 = read
- s_ready  out  1  — high only in IDLE; slave can accept
- s_rvalid  out  1  — one-cycle response strobe
- s_rdata  out  DATA_WIDTH  — read data, valid while s_rvalid
- s_err  out  1  — error flag, valid while s_rvalid

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: s_ready=1. On an edge where s_valid=1 and the ID equals SLAVE_ID, latch addr/wdata/wen and load wait counter = WAIT_STATES. Go to WAIT, or to RESP directly if WAIT_STATES=0. An ID mismatch is ignored and the FSM stays in IDLE.
- WAIT: counter decrements each cycle. The edge that leaves the final WAIT cycle is the commit edge, and the FSM moves to RESP.
- Commit edge, write: RAM[offset] ← wdata. Read: s_rdata ← RAM[offset].
- RESP: s_rvalid=1 for exactly one cycle, then IDLE.
- On writes, s_rdata is driven to 0 in RESP.
- No response backpressure: the master must sample s_rvalid when it occurs.
- s_valid while not IDLE is dropped, not queued. The master retries after s_ready.
- RAM contents are not reset.
- Offset out of range (offset ≥ MEM_DEPTH): handled per Configuration.

## Timing
- Reset values: s_ready=1, s_rvalid=0, s_rdata=0, s_err=0, state=IDLE, counter=0.
- Accept at edge k: s_ready=0 from k.
- Commit edge is k+WAIT_STATES. When WAIT_STATES=0, this is edge k itself, and request and commit share that edge.
- s_rvalid is high in the cycle after edge k+WAIT_STATES, and s_ready returns high at edge k+WAIT_STATES+1.
- Total: request-to-response latency is WAIT_STATES+1 cycles, and back-to-back throughput is one transaction per WAIT_STATES+2 cycles.
- Read-after-write to the same offset in the next transaction returns the new data.
- Reset asserted mid-transaction: outputs go to reset values immediately. A write whose commit edge has not occurred is lost, and no s_rvalid is issued for it.

## Configuration
- SLAVE_MEM_ERR_RESP_EN defined:
  - An out-of-range access performs no RAM write.
  - It returns s_rdata=0 with s_err=1 during RESP, using the same latency as a normal access.
- Not defined:
  - s_err is tied 0.
  - The offset wraps modulo MEM_DEPTH (MEM_DEPTH must be a power of two), so the access always succeeds.

## Test plan
- Defaults. Write 0x2ABC ← 8'h29 at edge k → s_rvalid high in the cycle after k+2, s_err=0. A following read of 0x2ABC → s_rdata=8'h29.
- Request 0x09AC / 8'h54 (ID 0 ≠ 2) → s_ready stays 1, no s_rvalid, and a later read of 0x29AC returns the previous contents unchanged.
- MEM_DEPTH=2048, macro on: write 0x2ABC (offset 2748) → s_err=1, s_rdata=0. A read of 0x22BC is unchanged.
- Same case, macro off: the write lands at offset 0x2BC, and a read of 0x22BC returns the written data.
- Busy drop:
  - Pulse a second s_valid (write 0x2001 ← 8'hAA) during WAIT → exactly one s_rvalid, and 0x2001 is unwritten.
  - Retry after s_ready → 8'hAA stored.
- WAIT_STATES=0 → s_rvalid in the cycle after the accept edge. Separately, with defaults, assert rstn low one cycle after a write is accepted → no s_rvalid, the RAM word is unchanged, and s_ready=1.
